ray_window_averager: RTL and testbench
======================================

Name: ray_window_averager

Overview:
Downstream stage of the ray/magnitude calculator in the bead-position path. Consumes the r, xSquare, ySquare, zSquare stream qualified by that stage's outData_valid. Averages each quantity over a fixed window of 2^LOG2_N accepted samples and emits one decimated, rounded result set per window to the feedback/readout logic.

Parameters:
DATA_WIDTH, 8, width of every input and output data word (unsigned fixed point, format passed through unchanged)
LOG2_N, 4, log2 of window length; window = 2^LOG2_N samples; legal range 1..10

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = accept samples; 0 = hold window cleared
clear  input  1  synchronous window restart, one-cycle pulse
in_valid  input  1  sample qualifier (upstream outData_valid)
r  input  DATA_WIDTH  magnitude sample
xSquare  input  DATA_WIDTH  x² sample
ySquare  input  DATA_WIDTH  y² sample
zSquare  input  DATA_WIDTH  z² sample
r_avg  output  DATA_WIDTH  windowed mean of r
xSquare_avg  output  DATA_WIDTH  windowed mean of xSquare
ySquare_avg  output  DATA_WIDTH  windowed mean of ySquare
zSquare_avg  output  DATA_WIDTH  windowed mean of zSquare
out_valid  output  1  one-cycle pulse: averages updated
window_count  output  LOG2_N  samples accepted in current window

Behaviour:
- Reset (reset=0, asynchronous): all accumulators, window_count, all *_avg, out_valid = 0.
- Accept: rising edge with enable=1, clear=0, in_valid=1. No backpressure; every qualified sample is taken.
- Accumulators: DATA_WIDTH+LOG2_N bits, unsigned. Overflow cannot occur by construction.
- Per-channel next sum = acc + in. It is combinational and used on the completing edge.
- Non-completing accept: acc <= acc + in; window_count increments.
- Completing accept (window_count = 2^LOG2_N-1):
  - *_avg <= (acc + in + 2^(LOG2_N-1)) >> LOG2_N, round half up.
  - Result never exceeds 2^DATA_WIDTH-1; no saturation logic.
  - acc <= 0; window_count wraps to 0.
  - out_valid = 1 during the following cycle only.
- Latency: out_valid and the new averages appear one cycle after the edge that accepts the last sample of the window.
- *_avg hold their value between windows.
- out_valid is 0 in every cycle not following a completing accept.
- clear=1 (sync): acc <= 0, window_count <= 0.
  - Priority over in_valid; a sample presented in the same cycle is discarded.
  - *_avg are not modified.
  - A completing sample coincident with clear produces no out_valid.
- enable=0: same as clear held; *_avg retain last value.
- enable rising: the first accepted sample starts a fresh window.
- Reset mid-window: partial sums lost; no out_valid issued.

Optional Feature:
RAY_WINDOW_PEAK_EN
- Defined:
  - Adds output r_max [DATA_WIDTH], plus an internal running maximum of r over the current window.
  - On a completing accept, r_max <= max(running_max, r), registered together with *_avg.
  - The running maximum resets to 0 on window wrap, clear, enable=0 and reset.
  - r_max = 0 after reset.
- Undefined: the port and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package calc_ray_pkg holds:
  - default DATA_WIDTH and LOG2_N constants;
  - the localparam for accumulator width (DATA_WIDTH+LOG2_N);
  - the rounding constant 2^(LOG2_N-1).
- Shared window control (window_count, completion detect, out_valid register) lives in the top module.
- Sub-module window_accumulator: one channel holding acc plus its avg register, with inputs accept/complete/restart. Instantiated 4 times via generate.

Test Plan:
- Rounding: DATA_WIDTH=8, LOG2_N=2.
  - r = 10, 20, 30, 40 on consecutive valid cycles -> r_avg = 25; out_valid high exactly one cycle, the cycle after sample 4.
  - r = 1, 1, 1, 2 -> r_avg = 1.
  - r = 1, 2, 2, 2 -> r_avg = 2.
- Full scale: four samples of 255 on all channels -> all *_avg = 255; no wrap; window_count returns to 0.
- Gapped valid: in_valid toggled 1, 0, 0, 1, 1, 0, 1 with xSquare = 8 -> xSquare_avg = 8 after the 4th accepted sample; no out_valid earlier.
- Clear mid-window:
  - Accept 3 samples of 100; assert clear together with a 4th sample -> no out_valid; window_count = 0; *_avg unchanged.
  - Next 4 samples of 4 -> avg = 4.
- Async reset mid-window: drop reset for a half clock after 2 samples -> all outputs 0 immediately; the next full window averages correctly.
- Peak (RAY_WINDOW_PEAK_EN defined): r = 5, 200, 7, 9 -> r_max = 200 and r_avg = 55. In the next window, r = 3, 3, 3, 3 -> r_max = 3.

Source files
------------

// File: rtl/calc_ray_pkg.sv
// Shared constants and helpers for the ray/magnitude window averaging path.
// Accumulator width and rounding constant derive from DATA_WIDTH and LOG2_N.
package calc_ray_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LOG2_N     = 4;
  localparam int ACC_WIDTH      = DEF_DATA_WIDTH + DEF_LOG2_N;
  localparam int ROUND_CONST    = 1 << (DEF_LOG2_N - 1);

  function automatic int acc_width(int dw, int ln);
    return dw + ln;
  endfunction

  function automatic int round_const(int ln);
    return 1 << (ln - 1);
  endfunction

endpackage

// File: rtl/ray_window_averager_accumulator.sv
// One averaging channel: window accumulator plus its rounded mean register.
// Mean is taken from the combinational next sum on the completing accept.
import calc_ray_pkg::*;

module window_accumulator #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_N     = DEF_LOG2_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic                  complete,
  input  logic                  restart,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] avg
);

  localparam int AW = acc_width(DATA_WIDTH, LOG2_N);
  localparam logic [AW-1:0] RND = AW'(round_const(LOG2_N));

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [AW-1:0] rounded;

  // Full-scale sum plus half LSB still fits in AW bits.
  assign sum     = acc + AW'(din);
  assign rounded = sum + RND;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      avg <= '0;
    end else if (restart) begin
      acc <= '0;
    end else if (accept) begin
      acc <= complete ? '0 : sum;
      if (complete)
        avg <= rounded[AW-1:LOG2_N];
    end
  end

endmodule

// File: rtl/ray_window_averager.sv
// Decimating window averager for r and x/y/z squares; one result per 2^LOG2_N samples.
// RAY_WINDOW_PEAK_EN adds r_max, the peak of r over each completed window.
import calc_ray_pkg::*;

module ray_window_averager #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_N     = DEF_LOG2_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] r,
  input  logic [DATA_WIDTH-1:0] xSquare,
  input  logic [DATA_WIDTH-1:0] ySquare,
  input  logic [DATA_WIDTH-1:0] zSquare,
  output logic [DATA_WIDTH-1:0] r_avg,
  output logic [DATA_WIDTH-1:0] xSquare_avg,
  output logic [DATA_WIDTH-1:0] ySquare_avg,
  output logic [DATA_WIDTH-1:0] zSquare_avg,
  output logic                  out_valid,
`ifdef RAY_WINDOW_PEAK_EN
  output logic [DATA_WIDTH-1:0] r_max,
`endif
  output logic [LOG2_N-1:0]     window_count
);

  logic                  restart;
  logic                  accept;
  logic                  complete;
  logic [DATA_WIDTH-1:0] din [4];
  logic [DATA_WIDTH-1:0] avg [4];

  // Disable behaves as a held clear.
  assign restart  = clear | ~enable;
  assign accept   = enable & ~clear & in_valid;
  assign complete = accept & (&window_count);

  assign din[0] = r;
  assign din[1] = xSquare;
  assign din[2] = ySquare;
  assign din[3] = zSquare;

  assign r_avg       = avg[0];
  assign xSquare_avg = avg[1];
  assign ySquare_avg = avg[2];
  assign zSquare_avg = avg[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_count <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= complete;
      if (restart)
        window_count <= '0;
      else if (accept)
        window_count <= window_count + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    window_accumulator #(
      .DATA_WIDTH(DATA_WIDTH),
      .LOG2_N    (LOG2_N)
    ) u_acc (
      .clk     (clk),
      .reset   (reset),
      .accept  (accept),
      .complete(complete),
      .restart (restart),
      .din     (din[g]),
      .avg     (avg[g])
    );
  end

`ifdef RAY_WINDOW_PEAK_EN
  logic [DATA_WIDTH-1:0] run_max;
  logic [DATA_WIDTH-1:0] next_max;

  assign next_max = (r > run_max) ? r : run_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max <= '0;
      r_max   <= '0;
    end else if (restart) begin
      run_max <= '0;
    end else if (accept) begin
      run_max <= complete ? '0 : next_max;
      if (complete)
        r_max <= next_max;
    end
  end
`endif

endmodule

// File: tb/tb_ray_window_averager.sv
// Self-checking bench for ray_window_averager (DATA_WIDTH=8, LOG2_N=2).
// Reference model keeps the accepted samples of the open window in queues.
module tb_ray_window_averager;

  localparam int DW = 8;
  localparam int LN = 2;
  localparam int WIN = 1 << LN;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] r = '0;
  logic [DW-1:0] xSquare = '0;
  logic [DW-1:0] ySquare = '0;
  logic [DW-1:0] zSquare = '0;
  logic [DW-1:0] r_avg;
  logic [DW-1:0] xSquare_avg;
  logic [DW-1:0] ySquare_avg;
  logic [DW-1:0] zSquare_avg;
  logic          out_valid;
  logic [LN-1:0] window_count;
`ifdef RAY_WINDOW_PEAK_EN
  logic [DW-1:0] r_max;
`endif

  int checks = 0;
  int errors = 0;

  int win_r[$];
  int win_x[$];
  int win_y[$];
  int win_z[$];
  int exp_avg[4];
  int exp_max;
  bit exp_ov;
  int exp_cnt;

  always #5 clk = ~clk;

  ray_window_averager #(
    .DATA_WIDTH(DW),
    .LOG2_N    (LN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .in_valid    (in_valid),
    .r           (r),
    .xSquare     (xSquare),
    .ySquare     (ySquare),
    .zSquare     (zSquare),
    .r_avg       (r_avg),
    .xSquare_avg (xSquare_avg),
    .ySquare_avg (ySquare_avg),
    .zSquare_avg (zSquare_avg),
    .out_valid   (out_valid),
`ifdef RAY_WINDOW_PEAK_EN
    .r_max       (r_max),
`endif
    .window_count(window_count)
  );

  function automatic int mean_of(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return (s + WIN / 2) / WIN;
  endfunction

  function automatic int max_of(input int q[$]);
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic model_flush();
    win_r.delete();
    win_x.delete();
    win_y.delete();
    win_z.delete();
  endtask

  task automatic model_reset();
    model_flush();
    for (int i = 0; i < 4; i++) exp_avg[i] = 0;
    exp_max = 0;
    exp_ov  = 0;
    exp_cnt = 0;
  endtask

  task automatic cyc(input bit v, input bit c, input bit e,
                     input int rv, input int xv, input int yv, input int zv);
    in_valid = v;
    clear    = c;
    enable   = e;
    r        = DW'(rv);
    xSquare  = DW'(xv);
    ySquare  = DW'(yv);
    zSquare  = DW'(zv);
    @(posedge clk);
    #1;
    exp_ov = 0;
    if (!e || c) begin
      model_flush();
    end else if (v) begin
      win_r.push_back(rv);
      win_x.push_back(xv);
      win_y.push_back(yv);
      win_z.push_back(zv);
      if (win_r.size() == WIN) begin
        exp_avg[0] = mean_of(win_r);
        exp_avg[1] = mean_of(win_x);
        exp_avg[2] = mean_of(win_y);
        exp_avg[3] = mean_of(win_z);
        exp_max    = max_of(win_r);
        exp_ov     = 1;
        model_flush();
      end
    end
    exp_cnt  = win_r.size();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ov got %0d want 0", out_valid);
    end
    checks++;
    if (window_count !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", window_count);
    end
    checks++;
    if ({r_avg, xSquare_avg, ySquare_avg, zSquare_avg} !== '0) begin
      errors++;
      $display("FAIL reset_avg got %h %h %h %h want 0", r_avg, xSquare_avg, ySquare_avg, zSquare_avg);
    end
`ifdef RAY_WINDOW_PEAK_EN
    checks++;
    if (r_max !== '0) begin
      errors++; $display("FAIL reset_max got %0d want 0", r_max);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rounding();
    int s [3][4];
    int want [3];
    s[0] = '{10, 20, 30, 40};
    s[1] = '{1, 1, 1, 2};
    s[2] = '{1, 2, 2, 2};
    want = '{25, 1, 2};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1, 0, 1, s[w][i], 0, 0, 0);
        checks++;
        if (out_valid !== (i == 3)) begin
          errors++; $display("FAIL rnd_ov w%0d s%0d got %0d want %0d", w, i, out_valid, i == 3);
        end
      end
      checks++;
      if (r_avg !== DW'(want[w])) begin
        errors++; $display("FAIL rnd_avg w%0d got %0d want %0d", w, r_avg, want[w]);
      end
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || r_avg !== 8'd2) begin
      errors++; $display("FAIL rnd_hold got ov=%0d avg=%0d want ov=0 avg=2", out_valid, r_avg);
    end
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 255, 255, 255, 255);
    checks++;
    if ({r_avg, xSquare_avg, ySquare_avg, zSquare_avg} !== {4{8'd255}}) begin
      errors++;
      $display("FAIL full_avg got %0d %0d %0d %0d want 255", r_avg, xSquare_avg, ySquare_avg, zSquare_avg);
    end
    checks++;
    if (window_count !== '0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_ctl got cnt=%0d ov=%0d want cnt=0 ov=1", window_count, out_valid);
    end
  endtask

  task automatic test_gapped();
    bit pat [7];
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cyc(pat[i], 0, 1, 0, 8, 0, 0);
      checks++;
      if (out_valid !== (i == 6)) begin
        errors++; $display("FAIL gap_ov c%0d got %0d want %0d", i, out_valid, i == 6);
      end
    end
    checks++;
    if (xSquare_avg !== 8'd8) begin
      errors++; $display("FAIL gap_avg got %0d want 8", xSquare_avg);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 100, 100, 100, 100);
    cyc(1, 1, 1, 100, 100, 100, 100);
    checks++;
    if (out_valid !== 1'b0 || window_count !== '0) begin
      errors++; $display("FAIL clr_ctl got ov=%0d cnt=%0d want ov=0 cnt=0", out_valid, window_count);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || xSquare_avg !== 8'd8 || r_avg !== 8'd0) begin
      errors++;
      $display("FAIL clr_hold got ov=%0d r=%0d x=%0d want ov=0 r=0 x=8", out_valid, r_avg, xSquare_avg);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 4, 4, 4, 4);
    checks++;
    if ({r_avg, xSquare_avg, ySquare_avg, zSquare_avg} !== {4{8'd4}} || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_next got %0d %0d %0d %0d ov=%0d want 4 ov=1", r_avg, xSquare_avg, ySquare_avg, zSquare_avg, out_valid);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 1, 50, 50, 50, 50);
    cyc(1, 0, 1, 50, 50, 50, 50);
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({r_avg, xSquare_avg, ySquare_avg, zSquare_avg} !== '0 || window_count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_out got r=%0d x=%0d cnt=%0d ov=%0d want 0", r_avg, xSquare_avg, window_count, out_valid);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 60 + i, 60 + i, 60 + i, 60 + i);
      checks++;
      if (out_valid !== (i == 3)) begin
        errors++; $display("FAIL arst_ov s%0d got %0d want %0d", i, out_valid, i == 3);
      end
    end
    checks++;
    if ({r_avg, zSquare_avg} !== {8'd62, 8'd62}) begin
      errors++; $display("FAIL arst_avg got %0d %0d want 62", r_avg, zSquare_avg);
    end
  endtask

  task automatic test_peak();
`ifdef RAY_WINDOW_PEAK_EN
    int s [4];
    s = '{5, 200, 7, 9};
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, s[i], 0, 0, 0);
    checks++;
    if (r_max !== 8'd200 || r_avg !== 8'd55) begin
      errors++; $display("FAIL peak_a got max=%0d avg=%0d want max=200 avg=55", r_max, r_avg);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 3, 0, 0, 0);
    checks++;
    if (r_max !== 8'd3) begin
      errors++; $display("FAIL peak_b got %0d want 3", r_max);
    end
`endif
  endtask

  task automatic test_random();
    bit v, c, e;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 24) != 0);
      cyc(v, c, e, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 255));
      checks++;
      if (out_valid !== exp_ov || window_count !== LN'(exp_cnt)) begin
        errors++;
        $display("FAIL rand_ctl n%0d got ov=%0d cnt=%0d want ov=%0d cnt=%0d", n, out_valid, window_count, exp_ov, exp_cnt);
      end
      checks++;
      if (r_avg !== DW'(exp_avg[0]) || xSquare_avg !== DW'(exp_avg[1]) ||
          ySquare_avg !== DW'(exp_avg[2]) || zSquare_avg !== DW'(exp_avg[3])) begin
        errors++;
        $display("FAIL rand_avg n%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", n,
                 r_avg, xSquare_avg, ySquare_avg, zSquare_avg,
                 exp_avg[0], exp_avg[1], exp_avg[2], exp_avg[3]);
      end
`ifdef RAY_WINDOW_PEAK_EN
      checks++;
      if (r_max !== DW'(exp_max)) begin
        errors++; $display("FAIL rand_max n%0d got %0d want %0d", n, r_max, exp_max);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_full_scale();
    test_gapped();
    test_clear();
    test_async_reset();
    test_peak();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
